// File: rtl/multiplicador_secuencial_if.sv
// multiplicador_secuencial_if: operand/product handshake bundle for the
// sequential multiplier. The signo field exists only when MULT_SIGNED_EN
// is defined.
interface multiplicador_secuencial_if #(
    parameter int N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
`ifdef MULT_SIGNED_EN
    logic           signo;
`endif
    logic [2*N-1:0] P;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    // Lane issue / writeback side
    modport master (
        output in_valid, A, B,
`ifdef MULT_SIGNED_EN
        output signo,
`endif
        output out_ready,
        input  in_ready, P, out_valid, busy
    );

    // Multiplier side
    modport slave (
        input  in_valid, A, B,
`ifdef MULT_SIGNED_EN
        input  signo,
`endif
        input  out_ready,
        output in_ready, P, out_valid, busy
    );
endinterface

// File: rtl/multiplicador_secuencial.sv
// multiplicador_secuencial: iterative shift-and-add N x N -> 2N multiplier,
// one pass of the shared N-bit ripple-carry adder per iteration.
// Optional feature macro: MULT_SIGNED_EN (adds signo input and NEG state for
// two's-complement operands).

module Sumador_Completo #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic carry;

    // Ripple-carry chain, LSB first
    always_comb begin
        carry = cin;
        s     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

module multiplicador_secuencial #(
    parameter int N = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    multiplicador_secuencial_if.slave    bus
);
    localparam int CW = $clog2(N);

`ifdef MULT_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_NEG, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

    state_t         state_q, state_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   acc_hi_q, acc_hi_d;
    logic [N-1:0]   acc_lo_q, acc_lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
`ifdef MULT_SIGNED_EN
    logic           neg_flag_q, neg_flag_d;
`endif

    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           carry;

    assign addend = acc_lo_q[0] ? mcand_q : '0;

    Sumador_Completo #(.N(N)) u_sumador (
        .a    (acc_hi_q),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.P         = {acc_hi_q, acc_lo_q};

    // State and datapath registers, synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            cnt_q      <= '0;
`ifdef MULT_SIGNED_EN
            neg_flag_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            cnt_q      <= cnt_d;
`ifdef MULT_SIGNED_EN
            neg_flag_q <= neg_flag_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        cnt_d      = cnt_q;
`ifdef MULT_SIGNED_EN
        neg_flag_d = neg_flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
`ifdef MULT_SIGNED_EN
                    // Magnitudes feed the unsigned datapath; -2^(N-1) maps to 2^(N-1)
                    mcand_d    = (bus.signo && bus.A[N-1]) ? (~bus.A + 1'b1) : bus.A;
                    acc_lo_d   = (bus.signo && bus.B[N-1]) ? (~bus.B + 1'b1) : bus.B;
                    neg_flag_d = bus.signo && (bus.A[N-1] ^ bus.B[N-1]);
`else
                    mcand_d    = bus.A;
                    acc_lo_d   = bus.B;
`endif
                    acc_hi_d   = '0;
                    cnt_d      = CW'(N - 1);
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                // Adder carry lands in acc_hi[N-1] after the shift
                {acc_hi_d, acc_lo_d} = {carry, sum, acc_lo_q[N-1:1]};
                if (cnt_q == '0) begin
`ifdef MULT_SIGNED_EN
                    state_d = neg_flag_q ? S_NEG : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef MULT_SIGNED_EN
            S_NEG: begin
                {acc_hi_d, acc_lo_d} = ~{acc_hi_q, acc_lo_q} + 1'b1;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Bench for multiplicador_secuencial: N=8 directed scenarios and N=32 random
// back-to-back traffic, expected products queued at accept time.
module tb_multiplicador_secuencial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiplicador_secuencial_if #(.N(8))  if8 ();
    multiplicador_secuencial_if #(.N(32)) if32 ();

    multiplicador_secuencial #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    multiplicador_secuencial #(.N(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] q8[$];
    logic [63:0] q32[$];

    // Drive one operand pair on the 8-bit DUT; call at a negedge with in_ready high
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        if8.A = a;
        if8.B = b;
        if8.in_valid = 1'b1;
        @(posedge clk);
        q8.push_back(exp);
        @(negedge clk);
        if8.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        if32.A = a;
        if32.B = b;
        if32.in_valid = 1'b1;
        @(posedge clk);
        q32.push_back(exp);
        @(negedge clk);
        if32.in_valid = 1'b0;
    endtask

    // Edges from the accepting edge until out_valid is seen (bounded)
    task automatic wait_valid8(output int unsigned lat);
        lat = 1;
        while (!if8.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume8();
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", if8.in_ready); end
        n_checks++; if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", if8.out_valid); end
        n_checks++; if (if8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", if8.busy); end
        n_checks++; if (if8.P !== 16'h0) begin n_fail++; $display("FAIL reset_P got=%h exp=0000", if8.P); end
        n_checks++; if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready32 got=%b exp=1", if32.in_ready); end
        n_checks++; if (if32.P !== 64'h0) begin n_fail++; $display("FAIL reset_P32 got=%h exp=0", if32.P); end
    endtask

    task automatic test_max();
        int unsigned lat;
        logic [15:0] exp;
        send8(8'd255, 8'd255, 16'hFE01);
        lat = 1;
        while (!if8.out_valid && lat < 60) begin
            n_checks++;
            if (if8.in_ready !== 1'b0 || if8.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL max_busy cycle=%0d in_ready=%b busy=%b exp in_ready=0 busy=1", lat, if8.in_ready, if8.busy);
            end
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL max_latency got=%0d exp=9", lat); end
        exp = q8.pop_front();
        n_checks++; if (if8.P !== exp) begin n_fail++; $display("FAIL max_product got=%h exp=%h", if8.P, exp); end
        consume8();
        n_checks++; if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL max_ready_after got=%b exp=1", if8.in_ready); end
    endtask

    task automatic test_zero_one();
        logic [7:0]  ta[6] = '{8'd0,  8'd91, 8'd1,   8'd128, 8'd255, 8'd2};
        logic [7:0]  tb[6] = '{8'd77, 8'd0,  8'd200, 8'd2,   8'd128, 8'd255};
        int unsigned lat;
        logic [15:0] exp;
        for (int i = 0; i < 6; i++) begin
            send8(ta[i], tb[i], 16'(ta[i]) * 16'(tb[i]));
            wait_valid8(lat);
            n_checks++; if (lat != 9) begin n_fail++; $display("FAIL zero_one_latency idx=%0d got=%0d exp=9", i, lat); end
            exp = q8.pop_front();
            n_checks++; if (if8.P !== exp) begin n_fail++; $display("FAIL zero_one_product idx=%0d got=%h exp=%h", i, if8.P, exp); end
            consume8();
        end
    endtask

    task automatic test_stall();
        int unsigned lat;
        logic [15:0] exp;
        send8(8'd13, 8'd11, 16'd143);
        wait_valid8(lat);
        exp = q8.pop_front();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                if8.A = 8'd3;
                if8.B = 8'd5;
                if8.in_valid = 1'b1;
            end else begin
                if8.in_valid = 1'b0;
            end
            n_checks++;
            if (if8.P !== exp || if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cycle=%0d P=%h valid=%b in_ready=%b exp P=%h valid=1 in_ready=0",
                         c, if8.P, if8.out_valid, if8.in_ready, exp);
            end
            @(negedge clk);
        end
        if8.in_valid = 1'b0;
        consume8();
        send8(8'd6, 8'd7, 16'd42);
        wait_valid8(lat);
        exp = q8.pop_front();
        n_checks++; if (if8.P !== exp) begin n_fail++; $display("FAIL stall_next_product got=%h exp=%h", if8.P, exp); end
        consume8();
        n_checks++; if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_after got=%b exp=1", if8.in_ready); end
    endtask

    task automatic test_reset_midcalc();
        int unsigned lat;
        int unsigned spurious = 0;
        logic [15:0] exp;
        send8(8'd100, 8'd100, 16'd10000);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q8.delete();
        n_checks++;
        if (if8.in_ready !== 1'b1 || if8.busy !== 1'b0 || if8.out_valid !== 1'b0 || if8.P !== 16'h0) begin
            n_fail++;
            $display("FAIL midcalc_reset in_ready=%b busy=%b valid=%b P=%h exp 1 0 0 0000",
                     if8.in_ready, if8.busy, if8.out_valid, if8.P);
        end
        for (int c = 0; c < 12; c++) begin
            if (if8.out_valid !== 1'b0) spurious++;
            @(negedge clk);
        end
        n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL midcalc_spurious_valid got=%0d exp=0", spurious); end
        send8(8'd7, 8'd9, 16'd63);
        wait_valid8(lat);
        exp = q8.pop_front();
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL midcalc_latency got=%0d exp=9", lat); end
        n_checks++; if (if8.P !== exp) begin n_fail++; $display("FAIL midcalc_product got=%h exp=%h", if8.P, exp); end
        consume8();
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        logic [7:0]  ta[4] = '{8'h80, 8'h80, 8'hFF, 8'hFB};
        logic [7:0]  tb[4] = '{8'h80, 8'h7F, 8'h01, 8'h00};
        logic [15:0] te[4] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000};
        int unsigned lat;
        logic [15:0] exp;
        if8.signo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send8(ta[i], tb[i], te[i]);
            wait_valid8(lat);
            n_checks++; if (lat != 10) begin n_fail++; $display("FAIL signed_latency idx=%0d got=%0d exp=10", i, lat); end
            exp = q8.pop_front();
            n_checks++; if (if8.P !== exp) begin n_fail++; $display("FAIL signed_product idx=%0d got=%h exp=%h", i, if8.P, exp); end
            consume8();
        end
        if8.signo = 1'b0;
        send8(8'hFF, 8'hFF, 16'hFE01);
        wait_valid8(lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL signo0_latency got=%0d exp=9", lat); end
        exp = q8.pop_front();
        n_checks++; if (if8.P !== exp) begin n_fail++; $display("FAIL signo0_product got=%h exp=%h", if8.P, exp); end
        consume8();
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] fa[4] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1};
        logic [31:0] fb[4] = '{32'hFFFF_FFFF, 32'd12345, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] a, b;
        logic [63:0] exp;
        longint unsigned ua, ub;
        logic sg;
        logic fin, done, checked;
        int unsigned cyc;
        for (int t = 0; t < 40; t++) begin
            a = (t < 4) ? fa[t] : $urandom;
            b = (t < 4) ? fb[t] : $urandom;
            sg = 1'b0;
`ifdef MULT_SIGNED_EN
            sg = (t >= 4) && $urandom_range(0, 1) == 1;
            if32.signo = sg;
`endif
            if (sg) begin
                longint sa, sb;
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                exp = 64'(sa * sb);
            end else begin
                ua = 64'(a);
                ub = 64'(b);
                exp = ua * ub;
            end
            n_checks++; if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready txn=%0d got=%b exp=1", t, if32.in_ready); end
            send32(a, b, exp);
            done = 1'b0;
            checked = 1'b0;
            cyc = 0;
            while (!done && cyc < 300) begin
                if (if32.out_valid && !checked) begin
                    exp = q32.pop_front();
                    n_checks++;
                    if (if32.P !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_product txn=%0d a=%h b=%h signo=%b got=%h exp=%h", t, a, b, sg, if32.P, exp);
                    end
                    checked = 1'b1;
                end
                if32.out_ready = ($urandom_range(0, 2) != 0);
                fin = if32.out_valid && if32.out_ready;
                @(negedge clk);
                cyc++;
                if (fin) done = 1'b1;
            end
            if32.out_ready = 1'b0;
            n_checks++; if (!done) begin n_fail++; $display("FAIL b2b_timeout txn=%0d got=no_output exp=output", t); end
        end
    endtask

    initial begin
        if8.in_valid = 1'b0;  if8.A = '0;  if8.B = '0;  if8.out_ready = 1'b0;
        if32.in_valid = 1'b0; if32.A = '0; if32.B = '0; if32.out_ready = 1'b0;
`ifdef MULT_SIGNED_EN
        if8.signo = 1'b0;
        if32.signo = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_max();
        test_zero_one();
        test_stall();
        test_reset_midcalc();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
